// File: rtl/flag_register_unit_pkg.sv
// -----------------------------------------------------------------------------
// flag_register_unit_pkg
//   Shared definitions for the O/S/C/Z flag producer:
//     - ALU operation class encodings
//     - flag bit positions (same order as the tester_flags pins: {O,S,C,Z})
//     - pipeline payload type and the masked-merge helper used for both
//       commit and forwarding
// -----------------------------------------------------------------------------
package flag_register_unit_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOGIC = 2'b10,
    OP_SHIFT = 2'b11
  } op_class_e;

  localparam int NUM_FLAGS = 4;
  localparam int FLAG_O    = 3;
  localparam int FLAG_S    = 2;
  localparam int FLAG_C    = 1;
  localparam int FLAG_Z    = 0;

  typedef logic [NUM_FLAGS-1:0] flags_t;

  // One in-flight flag write: the derived flags and which of them it writes.
  typedef struct packed {
    flags_t flags;
    flags_t mask;
  } flag_write_t;

  // Bits selected by mask come from new_f, the rest keep old_f.
  function automatic flags_t merge_flags(input flags_t old_f,
                                         input flags_t new_f,
                                         input flags_t mask);
    return (old_f & ~mask) | (new_f & mask);
  endfunction

endpackage

// File: rtl/flag_register_unit_if.sv
// -----------------------------------------------------------------------------
// flag_register_unit_if
//   ALU-to-flag-unit bus. The ALU/control side drives it (master); the flag
//   register unit consumes it (slave).
//     alu_valid  : ALU result valid this cycle
//     op_class   : ADD / SUB / LOGIC / SHIFT
//     flag_mask  : per-flag write enable {O,S,C,Z}
//     a, b       : operands as applied (b un-inverted for SUB)
//     result     : ALU result
//     carry_out  : ALU carry, or last shifted-out bit for SHIFT
//     hold       : pipeline stall
//     flush      : kill the EX-stage entry
// -----------------------------------------------------------------------------
interface flag_register_unit_if #(
  parameter int WIDTH = 16
);
  import flag_register_unit_pkg::*;

  logic             alu_valid;
  op_class_e        op_class;
  flags_t           flag_mask;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             hold;
  logic             flush;

  modport master (
    output alu_valid, op_class, flag_mask, a, b, result, carry_out, hold, flush
  );

  modport slave (
    input  alu_valid, op_class, flag_mask, a, b, result, carry_out, hold, flush
  );

endinterface

// File: rtl/flag_register_unit_flag_calc.sv
// -----------------------------------------------------------------------------
// flag_calc
//   Purely combinational flag derivation from one ALU result.
//   Ports:
//     op_class  in  operation class
//     a, b      in  operands (only the sign bits influence overflow)
//     result    in  ALU result
//     carry_out in  ALU carry / shifted-out bit
//     flags     out {O,S,C,Z}
// -----------------------------------------------------------------------------
module flag_calc
  import flag_register_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_class_e        op_class,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_out,
  output flags_t           flags
);

  localparam int MSB = WIDTH - 1;

  logic a_sign;
  logic b_sign;
  logic r_sign;

  assign a_sign = a[MSB];
  assign b_sign = b[MSB];
  assign r_sign = result[MSB];

  // Overflow depends only on operand signs; the low bits are carried on the
  // ports to keep the ALU hookup uniform.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{a[MSB-1:0], b[MSB-1:0]};

  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    //       this block leaves a bit unassigned and no latch is inferred.
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_S] = r_sign;
    case (op_class)
      OP_ADD: begin
        // Same-signed operands producing a differently-signed result.
        flags[FLAG_C] = carry_out;
        flags[FLAG_O] = (a_sign == b_sign) & (r_sign != a_sign);
      end
      OP_SUB: begin
        // a - b overflows only when the operand signs differ.
        flags[FLAG_C] = carry_out;
        flags[FLAG_O] = (a_sign != b_sign) & (r_sign != a_sign);
      end
      OP_SHIFT: begin
        flags[FLAG_C] = carry_out;
      end
      default: begin
        // LOGIC: C and O are architecturally cleared.
      end
    endcase
  end

endmodule

// File: rtl/flag_register_unit.sv
// -----------------------------------------------------------------------------
// flag_register_unit
//   Producer side of the O/S/C/Z flag interface. Flags are derived from each
//   ALU result, captured in EX, moved to WB and committed into the
//   architectural register. tester_flags sees forwarded flags where the
//   youngest pending write to each flag wins.
//   Ports:
//     clk           in   clock
//     reset         in   synchronous, active-high reset
//     alu           slave side of flag_register_unit_if (ALU bus, hold, flush)
//     O, S, C, Z    out  forwarded flags
//     arch_flags    out  committed register {O,S,C,Z}
//     flags_pending out  count of valid in-flight flag writes (0..2)
// -----------------------------------------------------------------------------
module flag_register_unit
  import flag_register_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  flag_register_unit_if.slave   alu,
  output logic                  O,
  output logic                  S,
  output logic                  C,
  output logic                  Z,
  output flags_t                arch_flags,
  output logic [1:0]            flags_pending
);

  flags_t      alu_flags;
  logic        capture_valid;

  logic        ex_valid;
  logic        wb_valid;
  flag_write_t ex_q;
  flag_write_t wb_q;
  flags_t      arch_q;
  flags_t      fwd_flags;

  flag_calc #(
    .WIDTH (WIDTH)
  ) u_flag_calc (
    .op_class  (alu.op_class),
    .a         (alu.a),
    .b         (alu.b),
    .result    (alu.result),
    .carry_out (alu.carry_out),
    .flags     (alu_flags)
  );

  // An instruction writing no flags never occupies a stage, so it neither
  // forwards nor counts as pending. A flush on the capture edge kills it too.
  assign capture_valid = alu.alu_valid & (|alu.flag_mask) & ~alu.flush;

  // Control state: stage valids and the architectural register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples the pre-edge value of the others (wb_valid takes the old
    //       ex_valid, arch_q merges the old wb_q).
    if (reset) begin
      ex_valid <= 1'b0;
      wb_valid <= 1'b0;
      arch_q   <= '0;
    end else if (alu.hold) begin
      // Stalled: nothing moves, but a taken branch still kills EX.
      if (alu.flush) begin
        ex_valid <= 1'b0;
      end
    end else begin
      ex_valid <= capture_valid;
      wb_valid <= ex_valid & ~alu.flush;
      if (wb_valid) begin
        arch_q <= merge_flags(arch_q, wb_q.flags, wb_q.mask);
      end
    end
  end

  // Payload registers.
  // NOTE: payload carries no reset; it is only observed when the matching
  //       valid bit is set, and the valids are reset above.
  always_ff @(posedge clk) begin
    if (!alu.hold) begin
      ex_q <= '{flags: alu_flags, mask: alu.flag_mask};
      wb_q <= ex_q;
    end
  end

  // Forwarding: architectural value, overlaid by WB, overlaid by the younger
  // EX entry. Stage masks are qualified by their valid bits.
  always_comb begin
    fwd_flags = arch_q;
    fwd_flags = merge_flags(fwd_flags, wb_q.flags, wb_q.mask & {NUM_FLAGS{wb_valid}});
    fwd_flags = merge_flags(fwd_flags, ex_q.flags, ex_q.mask & {NUM_FLAGS{ex_valid}});
  end

  assign O             = fwd_flags[FLAG_O];
  assign S             = fwd_flags[FLAG_S];
  assign C             = fwd_flags[FLAG_C];
  assign Z             = fwd_flags[FLAG_Z];
  assign arch_flags    = arch_q;
  assign flags_pending = {1'b0, ex_valid} + {1'b0, wb_valid};

endmodule

// File: tb/tb_flag_register_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_register_unit
//   Self-checking bench. The reference model keeps in-flight flag writes in a
//   queue (front = youngest) and derives flags from signed arithmetic.
// -----------------------------------------------------------------------------
module tb_flag_register_unit;
  import flag_register_unit_pkg::*;

  localparam int WIDTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       O, S, C, Z;
  logic [3:0] arch_flags;
  logic [1:0] flags_pending;

  flag_register_unit_if #(.WIDTH(WIDTH)) bus ();

  flag_register_unit #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu           (bus),
    .O             (O),
    .S             (S),
    .C             (C),
    .Z             (Z),
    .arch_flags    (arch_flags),
    .flags_pending (flags_pending)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit         live;
    logic [3:0] flags;
    logic [3:0] mask;
  } entry_t;

  entry_t     pipe[$];
  logic [3:0] m_arch;

  function automatic logic [3:0] ref_flags(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] r,
                                           input logic c);
    int  sa, sb, val;
    bit  o, s, cf, z;
    sa = int'($signed(a));
    sb = int'($signed(b));
    z  = (r == 16'd0);
    s  = (int'(r) >= 32768);
    o  = 1'b0;
    cf = 1'b0;
    case (op)
      2'b00: begin val = sa + sb; o = (val > 32767) || (val < -32768); cf = c; end
      2'b01: begin val = sa - sb; o = (val > 32767) || (val < -32768); cf = c; end
      2'b11: cf = c;
      default: ;
    endcase
    return {o, s, cf, z};
  endfunction

  function automatic logic [3:0] model_fwd();
    logic [3:0] v;
    v = m_arch;
    // Oldest first so younger entries overwrite.
    for (int k = pipe.size() - 1; k >= 0; k--)
      if (pipe[k].live)
        for (int i = 0; i < 4; i++)
          if (pipe[k].mask[i]) v[i] = pipe[k].flags[i];
    return v;
  endfunction

  function automatic int model_pending();
    int n;
    n = 0;
    foreach (pipe[k]) if (pipe[k].live) n++;
    return n;
  endfunction

  function automatic void model_clear();
    entry_t dead;
    dead  = '{live: 1'b0, flags: 4'h0, mask: 4'h0};
    pipe  = {};
    pipe.push_back(dead);
    pipe.push_back(dead);
    m_arch = 4'h0;
  endfunction

  // Advance the model with the inputs currently applied, clock once, compare.
  task automatic step(input string tag);
    entry_t e, old;
    if (reset) begin
      model_clear();
    end else if (bus.hold) begin
      if (bus.flush) begin e = pipe[0]; e.live = 1'b0; pipe[0] = e; end
    end else begin
      old = pipe.pop_back();
      if (old.live)
        for (int i = 0; i < 4; i++) if (old.mask[i]) m_arch[i] = old.flags[i];
      if (bus.flush) begin e = pipe[0]; e.live = 1'b0; pipe[0] = e; end
      e.live  = bus.alu_valid && (bus.flag_mask != 4'h0) && !bus.flush;
      e.flags = ref_flags(bus.op_class, bus.a, bus.b, bus.result, bus.carry_out);
      e.mask  = bus.flag_mask;
      pipe.push_front(e);
    end
    @(posedge clk);
    #1;
    check({tag, ".fwd"},  {28'd0, O, S, C, Z},     {28'd0, model_fwd()});
    check({tag, ".arch"}, {28'd0, arch_flags},    {28'd0, m_arch});
    check({tag, ".pend"}, {30'd0, flags_pending}, model_pending());
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.hold      = 1'b0;
    bus.flush     = 1'b0;
    bus.flag_mask = 4'h0;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [3:0] mask, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] r, input logic c);
    bus.alu_valid = 1'b1;
    bus.hold      = 1'b0;
    bus.flush     = 1'b0;
    bus.op_class  = op_class_e'(op);
    bus.flag_mask = mask;
    bus.a         = a;
    bus.b         = b;
    bus.result    = r;
    bus.carry_out = c;
  endtask

  // Architecturally consistent random ALU operation.
  task automatic random_op();
    logic [1:0]  op;
    logic [15:0] a, b, r;
    logic [16:0] wide;
    logic        c;
    int          n;
    op = 2'($urandom_range(0, 3));
    a  = 16'($urandom);
    b  = 16'($urandom);
    if ($urandom_range(0, 7) == 0) b = a;
    case (op)
      2'b00: begin wide = {1'b0, a} + {1'b0, b}; r = wide[15:0]; c = wide[16]; end
      2'b01: begin r = a - b; c = (a >= b); end
      2'b10: begin
        if ($urandom_range(0, 3) == 0) r = a & ~a;
        else                           r = a ^ b;
        c = 1'($urandom);
      end
      default: begin
        n = $urandom_range(1, 15);
        r = a << n;
        c = a[16 - n];
      end
    endcase
    set_op(op, 4'($urandom_range(0, 15)), a, b, r, c);
    bus.alu_valid = ($urandom_range(0, 9) < 7);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_clear();
    reset = 1'b1;
    idle();
    bus.op_class  = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.result    = '0;
    bus.carry_out = 1'b0;
    step("rst0");
    step("rst1");
    reset = 1'b0;

    // ADD overflow into the sign bit.
    set_op(2'b00, 4'hF, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
    step("t2_cap");
    check("t2_fwd", {28'd0, O, S, C, Z}, 32'b1100);
    idle();
    step("t2_wb");
    step("t2_commit");
    check("t2_arch", {28'd0, arch_flags}, 32'b1100);

    // SUB to zero, then a Z-only LOGIC back to back.
    set_op(2'b01, 4'hF, 16'h0005, 16'h0005, 16'h0000, 1'b1);
    step("t3_sub");
    check("t3_fwd1", {28'd0, O, S, C, Z}, 32'b0011);
    set_op(2'b10, 4'h1, 16'h00FF, 16'h0FF0, 16'h00F0, 1'b0);
    step("t3_logic");
    check("t3_fwd2", {28'd0, O, S, C, Z}, 32'b0010);
    idle();
    step("t3_drain0");
    step("t3_drain1");
    check("t3_arch", {28'd0, arch_flags}, 32'b0010);

    // Flush on the capture edge discards the instruction.
    set_op(2'b00, 4'hF, 16'h7FFF, 16'h7FFF, 16'hFFFE, 1'b0);
    bus.flush = 1'b1;
    step("t4_flush");
    check("t4_fwd",  {28'd0, O, S, C, Z},     32'b0010);
    check("t4_pend", {30'd0, flags_pending}, 32'd0);
    idle();
    step("t4_d0");
    step("t4_d1");
    check("t4_arch", {28'd0, arch_flags}, 32'b0010);

    // Hold with both stages valid.
    set_op(2'b00, 4'hF, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    step("t5_i0");
    set_op(2'b01, 4'hF, 16'h8000, 16'h0001, 16'h7FFF, 1'b1);
    step("t5_i1");
    for (int k = 0; k < 3; k++) begin
      random_op();
      bus.hold = 1'b1;
      step("t5_hold");
      check("t5_hold_pend", {30'd0, flags_pending}, 32'd2);
      check("t5_hold_fwd",  {28'd0, O, S, C, Z},     32'b1010);
      check("t5_hold_arch", {28'd0, arch_flags},    32'b0010);
    end
    idle();
    step("t5_r0");
    check("t5_commit0", {28'd0, arch_flags}, 32'b0000);
    step("t5_r1");
    check("t5_commit1", {28'd0, arch_flags}, 32'b1010);

    // Partial-mask SHIFT: only S and C written; O and Z come from arch.
    set_op(2'b10, 4'h1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step("t6_pre");
    idle();
    step("t6_pre_d0");
    step("t6_pre_d1");
    set_op(2'b11, 4'h6, 16'h8000, 16'h0001, 16'h0000, 1'b1);
    step("t6_shift");
    check("t6_fwd", {28'd0, O, S, C, Z}, 32'b1011);

    // Randomized traffic with hold, flush and occasional reset.
    for (int n = 0; n < 400; n++) begin
      random_op();
      bus.hold  = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 6) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      step("rand");
    end

    // Reset after random traffic; reset overrides hold and flush.
    random_op();
    bus.hold = 1'b1;
    reset    = 1'b1;
    step("t1_rst0");
    bus.hold = 1'b0;
    step("t1_rst1");
    check("t1_fwd",  {28'd0, O, S, C, Z},     32'd0);
    check("t1_arch", {28'd0, arch_flags},    32'd0);
    check("t1_pend", {30'd0, flags_pending}, 32'd0);
    reset = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
